// File: rtl/datamem_pkg.sv
// Shared types and helpers for the data-memory responder (64-bit lanes, byte addressed).
package datamem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'b00,
    MEM_HALF   = 2'b01,
    MEM_WORD   = 2'b10,
    MEM_DOUBLE = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } datamem_state_e;

  localparam int unsigned WaitCntW = 4;
  localparam int unsigned OffW     = 3;

  function automatic int unsigned data_width(int unsigned pow);
    return 1 << pow;
  endfunction

  function automatic int unsigned addr_width(int unsigned pow);
    return 1 << pow;
  endfunction

  // Misaligned offsets are rounded down to the natural alignment of the size.
  function automatic logic [OffW-1:0] align_off(mem_size_e size, logic [OffW-1:0] off);
    logic [OffW-1:0] res;
    unique case (size)
      MEM_BYTE:   res = off;
      MEM_HALF:   res = {off[2:1], 1'b0};
      MEM_WORD:   res = {off[2], 2'b00};
      MEM_DOUBLE: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(mem_size_e size, logic [OffW-1:0] off);
    return off != align_off(size, off);
  endfunction

  function automatic logic [7:0] byte_mask(mem_size_e size, logic [OffW-1:0] off);
    logic [7:0] base;
    unique case (size)
      MEM_BYTE:   base = 8'h01;
      MEM_HALF:   base = 8'h03;
      MEM_WORD:   base = 8'h0F;
      MEM_DOUBLE: base = 8'hFF;
    endcase
    return base << align_off(size, off);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the load/store unit and the data memory.
// The misaligned line exists only when DATAMEM_MISALIGN_TRAP_EN is defined.
interface data_mem_responder_if #(
    parameter int unsigned DATA_WIDTH_POW = 6,
    parameter int unsigned ADDR_WIDTH_POW = 6
);
  import datamem_pkg::*;

  localparam int unsigned DataWidth = data_width(DATA_WIDTH_POW);
  localparam int unsigned AddrWidth = addr_width(ADDR_WIDTH_POW);

  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] data_in;
  logic                 writeEnable;
  logic                 readEnable;
  logic [1:0]           size;
  logic                 loadUnsigned;
  logic [DataWidth-1:0] data_out;
  logic                 ready;
`ifdef DATAMEM_MISALIGN_TRAP_EN
  logic                 misaligned;
`endif

  modport master (
    output addr, data_in, writeEnable, readEnable, size, loadUnsigned,
`ifdef DATAMEM_MISALIGN_TRAP_EN
    input  misaligned,
`endif
    input  data_out, ready
  );

  modport slave (
    input  addr, data_in, writeEnable, readEnable, size, loadUnsigned,
`ifdef DATAMEM_MISALIGN_TRAP_EN
    output misaligned,
`endif
    output data_out, ready
  );

endinterface

// File: rtl/datamem_load_extend.sv
// Load-path lane extraction with sign/zero extension to the full data width.
module datamem_load_extend
  import datamem_pkg::*;
#(
    parameter int unsigned DataWidth = 64
) (
    input  logic [DataWidth-1:0] word_i,
    input  mem_size_e            size_i,
    input  logic [OffW-1:0]      off_i,
    input  logic                 unsigned_i,
    output logic [DataWidth-1:0] data_o
);

  logic [DataWidth-1:0] shifted;
  logic                 fill;

  assign shifted = word_i >> {off_i, 3'b000};

  always_comb begin
    fill   = 1'b0;
    data_o = shifted;
    unique case (size_i)
      MEM_BYTE: begin
        fill   = ~unsigned_i & shifted[7];
        data_o = {{(DataWidth - 8){fill}}, shifted[7:0]};
      end
      MEM_HALF: begin
        fill   = ~unsigned_i & shifted[15];
        data_o = {{(DataWidth - 16){fill}}, shifted[15:0]};
      end
      MEM_WORD: begin
        fill   = ~unsigned_i & shifted[31];
        data_o = {{(DataWidth - 32){fill}}, shifted[31:0]};
      end
      MEM_DOUBLE: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data memory answering sized loads/stores with a one-cycle ready pulse.
// Optional DATAMEM_MISALIGN_TRAP_EN turns misaligned accesses into faults instead of truncating.
module data_mem_responder
  import datamem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_POW = 6,
    parameter int unsigned ADDR_WIDTH_POW = 6,
    parameter int unsigned DEPTH_WORDS    = 512,
    parameter int unsigned WAIT_STATES    = 1
) (
    input logic clk,
    input logic reset,
    data_mem_responder_if.slave bus
);

  localparam int unsigned DataWidth = data_width(DATA_WIDTH_POW);
  localparam int unsigned AddrWidth = addr_width(ADDR_WIDTH_POW);
  localparam int unsigned NumBytes  = DataWidth / 8;
  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);

  datamem_state_e        state_q, state_d;
  logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  mem_size_e             size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  write_q, write_d;
  logic                  ready_q, ready_d;
  logic [DataWidth-1:0]  dout_q, dout_d;
  logic                  fault_q, fault_d;

  logic [DataWidth-1:0]  mem [DEPTH_WORDS];
  logic [DataWidth-1:0]  rd_word;
  logic [DataWidth-1:0]  load_data;
  logic [DataWidth-1:0]  wr_data;
  logic [7:0]            wr_mask;
  logic [OffW-1:0]       off_al;
  logic                  req;
  logic                  access_fault;
  logic                  commit;
  logic                  unused_addr;

  assign unused_addr = ^bus.addr[AddrWidth-1:OffW+IdxW];

  assign req     = bus.writeEnable | bus.readEnable;
  assign rd_word = mem[idx_q];
  assign off_al  = align_off(size_q, off_q);
  assign wr_mask = byte_mask(size_q, off_q);
  assign wr_data = wdata_q << {off_al, 3'b000};

`ifdef DATAMEM_MISALIGN_TRAP_EN
  assign access_fault = is_misaligned(size_q, off_q);
`else
  assign access_fault = 1'b0;
`endif

  datamem_load_extend #(
    .DataWidth(DataWidth)
  ) u_load_extend (
    .word_i    (rd_word),
    .size_i    (size_q),
    .off_i     (off_al),
    .unsigned_i(uns_q),
    .data_o    (load_data)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    write_d    = write_q;
    ready_d    = 1'b0;
    dout_d     = dout_q;
    fault_d    = 1'b0;
    unique case (state_q)
      // The ready cycle accepts a new request so back-to-back accesses lose no cycle.
      StIdle, StResp: begin
        if (req) begin
          idx_d      = bus.addr[OffW +: IdxW];
          off_d      = bus.addr[OffW-1:0];
          wdata_d    = bus.data_in;
          size_d     = mem_size_e'(bus.size);
          uns_d      = bus.loadUnsigned;
          write_d    = bus.writeEnable;
          wait_cnt_d = WaitCntW'(WAIT_STATES);
          state_d    = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d = StResp;
          ready_d = 1'b1;
          fault_d = access_fault;
          if (access_fault) begin
            dout_d = '0;
          end else if (!write_q) begin
            dout_d = load_data;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      size_q     <= MEM_BYTE;
      uns_q      <= 1'b0;
      write_q    <= 1'b0;
      ready_q    <= 1'b0;
      dout_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      write_q    <= write_d;
      ready_q    <= ready_d;
      dout_q     <= dout_d;
      fault_q    <= fault_d;
    end
  end

  // Stores land at the edge closing the ready cycle; reset before then discards them.
  assign commit = (state_q == StResp) && write_q && !fault_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (commit && wr_mask[i]) begin
        mem[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.data_out = dout_q;
`ifdef DATAMEM_MISALIGN_TRAP_EN
  assign bus.misaligned = fault_q;
`endif

endmodule
